// File: rtl/sync_debounce_pkg.sv
// Shared types and defaults for the synchronizing debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sync_debounce_pkg;

   // Qualification FSM; the CHK_* states are the "busy" states.
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// Multi-flop synchronizer chain for bringing one asynchronous bit into clk.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running level path.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw level through the chain; only the last stage is trusted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronizes and debounces a bouncing input into a clean level plus edge pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk edges with tick tied high.
// Backpressure: none; counting simply pauses on cycles without tick.
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic din_async,
   input  logic tick,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   // Counter only ever needs to reach DEBOUNCE_CYCLES-1, so it never wraps.
   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dout_q;
   logic             rise_q;
   logic             fall_q;
   logic             busy_q;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din_async),
      .q     (s)
   );

   // Qualification FSM: a new level is accepted only after DEBOUNCE_CYCLES
   // consecutive ticks that all see it; entering CHK_* counts as the first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // Pulses last exactly one clk unless re-armed below.
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (tick) begin
            case (state_q)
               STABLE_LO: begin
                  if (s) begin
                     state_q <= CHK_HI;
                     cnt_q   <= CNT_ONE;
                     busy_q  <= 1'b1;
                  end
               end
               CHK_HI: begin
                  if (!s) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     dout_q  <= 1'b1;
                     rise_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               STABLE_HI: begin
                  if (!s) begin
                     state_q <= CHK_LO;
                     cnt_q   <= CNT_ONE;
                     busy_q  <= 1'b1;
                  end
               end
               CHK_LO: begin
                  if (s) begin
                     state_q <= STABLE_HI;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= STABLE_LO;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                     dout_q  <= 1'b0;
                     fall_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = busy_q;

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
Input conditioner that sits directly upstream of the dff data input. It takes an asynchronous, possibly bouncing level such as a switch or external strobe and synchronizes it into the clk domain. It filters out glitches shorter than a programmable number of sample ticks. It then presents a clean level plus single-cycle rise/fall pulses that the downstream flip-flop stage and its consumers can sample safely.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops; legal values >= 2.
DEBOUNCE_CYCLES, 4, number of consecutive qualifying ticks required to accept a new level; legal values >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
din_async  input  1  raw asynchronous input level.
tick  input  1  sample enable; debounce counting advances only on cycles with tick=1; tie to 1 for per-clock counting.
dout  output  1  debounced, synchronized level; registered.
rise  output  1  one-clk pulse on the cycle dout goes 0->1; registered.
fall  output  1  one-clk pulse on the cycle dout goes 1->0; registered.
busy  output  1  high while a candidate level change is being qualified (CHK_HI/CHK_LO).

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. While reset=1:
  - all synchronizer flops = 0, state = STABLE_LO, cnt = 0;
  - dout = 0, rise = 0, fall = 0, busy = 0.
  - Reset applies immediately, including mid-qualification; no pulse is emitted on reset entry or exit.
- Synchronizer: din_async passes through SYNC_STAGES flops; s = last stage output. The FSM uses only s.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: tick && s=1 -> CHK_HI, cnt=1. Otherwise hold.
  - CHK_HI, on tick:
    - s=0 -> STABLE_LO, cnt=0; glitch rejected, no output change.
    - s=1 && cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0, dout<=1, rise<=1.
    - s=1 otherwise -> cnt++.
  - CHK_HI, tick=0: hold state and cnt, even if s changes.
  - STABLE_HI / CHK_LO: mirror of the above with s=0, dout<=0, fall<=1.
- rise/fall: high for exactly one clk, the same cycle dout changes. Never both high. Forced 0 on every other cycle.
- busy = (state==CHK_HI || state==CHK_LO), registered with the state.
- Latency with tick tied high: din_async stable high before edge 1 -> dout=1 and rise=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 with defaults). Same for falling.
- Glitch: a change of s lasting fewer than DEBOUNCE_CYCLES ticks produces no change on dout/rise/fall.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- No combinational path from din_async or tick to any output.

Decomposition:
- Package sync_debounce_pkg holds:
  - the state enum typedef (STABLE_LO, CHK_HI, STABLE_HI, CHK_LO), 2-bit encoding;
  - default parameter constants.
- One sub-module: sync_chain. It is a parameterised SYNC_STAGES-deep flop chain with async active-high reset to 0, reusable by other CDC inputs.
- FSM, counter and pulse logic live in sync_debounce.

Test Plan:
1. Reset then hold din_async=0 for 20 clk, tick=1 -> dout=0, rise=fall=busy=0 throughout.
2. Raise din_async=1 before edge 1, tick=1, defaults:
   - busy=1 from edge 3;
   - dout=1 and rise=1 after edge 6, rise=0 after edge 7;
   - busy=0 after edge 6.
3. Glitch, din_async=1 for 3 clk then 0 -> s high 3 cycles, busy pulses, dout stays 0, no rise/fall. Repeat at high level with a 3-clk low glitch -> dout stays 1, no fall.
4. Tick gating:
   - tick=1 every 4th clk, din_async held high -> dout rises only after the 4th qualifying tick (cnt holds between ticks);
   - toggling s between ticks while cnt is mid-count does not reset cnt.
5. Reset mid-qualification: assert reset asynchronously while in CHK_HI with cnt=2 -> all outputs 0 immediately. After deassert with din_async still 1 -> full SYNC_STAGES+DEBOUNCE_CYCLES latency again, single rise.
6. Full cycle at DEBOUNCE_CYCLES=2, SYNC_STAGES=3: din 0->1->0, each level held 10 clk -> exactly one rise and one fall, each 1 clk wide, dout latency 5 clk per edge.
